// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder.
//   SymW        - width of one TMDS symbol
//   CntW        - width of the per-channel running-disparity counter
//   CtrlCodeXX  - control-period symbols for {c1,c0} = XX
//   ctrl_code() - control-period symbol for a {c1,c0} pair
//   popcount8() - number of ones in a byte
//   transition_min() - stage-1 transition-minimised word q_m[8:0]
package tmds_pkg;

  localparam int unsigned SymW = 10;
  localparam int unsigned CntW = 5;

  localparam logic [SymW-1:0] CtrlCode00 = 10'b1101010100;
  localparam logic [SymW-1:0] CtrlCode01 = 10'b0010101011;
  localparam logic [SymW-1:0] CtrlCode10 = 10'b0101010100;
  localparam logic [SymW-1:0] CtrlCode11 = 10'b1010101011;

  function automatic logic [SymW-1:0] ctrl_code(input logic [1:0] c);
    logic [SymW-1:0] sym;
    unique case (c)
      2'b00:   sym = CtrlCode00;
      2'b01:   sym = CtrlCode01;
      2'b10:   sym = CtrlCode10;
      default: sym = CtrlCode11;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // XNOR chain when the byte is ones-heavy (ties broken by d[0]==0), XOR chain
  // otherwise; q_m[8] records which chain was used (1 = XOR).
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = qm[i-1] ^ d[i] ^ use_xnor;
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-in / symbol-out bundle of the TMDS encoder.
//   rgb   - {R[23:16],G[15:8],B[7:0]}, valid when de=1
//   hsync - horizontal sync, raw polarity
//   vsync - vertical sync, raw polarity
//   de    - 1 = active video, 0 = control period
//   tmds0/1/2 - blue/green/red 10-bit symbols, bit 0 transmitted first
// master: pixel source; slave: the encoder.
interface tmds_encoder_if;
  import tmds_pkg::*;

  logic [23:0]     rgb;
  logic            hsync;
  logic            vsync;
  logic            de;
  logic [SymW-1:0] tmds0;
  logic [SymW-1:0] tmds1;
  logic [SymW-1:0] tmds2;

  modport master (
    output rgb, hsync, vsync, de,
    input  tmds0, tmds1, tmds2
  );

  modport slave (
    input  rgb, hsync, vsync, de,
    output tmds0, tmds1, tmds2
  );

endinterface

// File: rtl/tmds_chan.sv
// One TMDS 8b/10b channel, two pipeline stages.
//   clk - pixel clock
//   rst - asynchronous active-high reset
//   d   - data byte (used when de=1)
//   c   - {c1,c0} control bits (used when de=0)
//   de  - 1 = data symbol, 0 = control symbol
//   q   - registered 10-bit symbol, 2 clk after d/c/de
// Stage 1 registers q_m and its ones count; stage 2 applies DC balance using
// the channel's running disparity counter cnt_q.
module tmds_chan
  import tmds_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      d,
  input  logic [1:0]      c,
  input  logic            de,
  output logic [SymW-1:0] q
);

  // Stage 1
  logic [8:0] qm_d, qm_q;
  logic [3:0] n1_d, n1_q;
  logic       de_q;
  logic [1:0] c_q;

  always_comb begin
    qm_d = transition_min(d);
    n1_d = popcount8(qm_d[7:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_q <= '0;
      n1_q <= '0;
      de_q <= 1'b0;
      c_q  <= '0;
    end else begin
      qm_q <= qm_d;
      n1_q <= n1_d;
      de_q <= de;
      c_q  <= c;
    end
  end

  // Stage 2
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [CntW-1:0] diff;  // N1 - N0, modulo 2^CntW
  logic [SymW-1:0] q_d;
  logic            cnt_zero, cnt_pos, cnt_neg;
  logic            n1_gt, n0_gt, bal;

  always_comb begin
    diff     = CntW'({n1_q, 1'b0}) - CntW'(8);
    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[CntW-1];
    cnt_pos  = !cnt_neg && !cnt_zero;
    n1_gt    = (n1_q > 4'd4);
    n0_gt    = (n1_q < 4'd4);
    bal      = (n1_q == 4'd4);
    q_d      = ctrl_code(c_q);
    cnt_d    = '0;
    if (de_q) begin
      if (cnt_zero || bal) begin
        q_d   = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
        cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((cnt_pos && n1_gt) || (cnt_neg && n0_gt)) begin
        q_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + (qm_q[8] ? CntW'(2) : '0) - diff;
      end else begin
        q_d   = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - (qm_q[8] ? '0 : CntW'(2)) + diff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= CtrlCode00;
      cnt_q <= '0;
    end else begin
      q     <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS encoder: three tmds_chan instances fed from one pixel bus.
//   clk - pixel clock
//   rst - asynchronous active-high reset
//   bus - tmds_encoder_if slave: rgb/hsync/vsync/de in, tmds0/1/2 out
// Parameter SYNC_INV = 1 inverts hsync/vsync before control encoding.
// Latency is 2 clk for every channel, so symbols stay aligned.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter bit SYNC_INV = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  tmds_encoder_if.slave bus
);

  // Only the blue channel carries syncs in the control period.
  logic [1:0] ctrl0;
  assign ctrl0 = {bus.vsync ^ SYNC_INV, bus.hsync ^ SYNC_INV};

  tmds_chan u_chan0 (
    .clk (clk),
    .rst (rst),
    .d   (bus.rgb[7:0]),
    .c   (ctrl0),
    .de  (bus.de),
    .q   (bus.tmds0)
  );

  tmds_chan u_chan1 (
    .clk (clk),
    .rst (rst),
    .d   (bus.rgb[15:8]),
    .c   (2'b00),
    .de  (bus.de),
    .q   (bus.tmds1)
  );

  tmds_chan u_chan2 (
    .clk (clk),
    .rst (rst),
    .d   (bus.rgb[23:16]),
    .c   (2'b00),
    .de  (bus.de),
    .q   (bus.tmds2)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
module tb_tmds_encoder;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  typedef struct packed {
    logic [2:0][9:0] sym;
    logic [23:0]     rgb;
    logic            de;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tmds_encoder_if bus0 ();
  tmds_encoder_if bus1 ();

  assign bus1.rgb   = bus0.rgb;
  assign bus1.hsync = bus0.hsync;
  assign bus1.vsync = bus0.vsync;
  assign bus1.de    = bus0.de;

  tmds_encoder #(.SYNC_INV(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tmds_encoder #(.SYNC_INV(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: per-channel running disparity and the symbol that will
  // appear at the outputs after the next clock edge.
  int    mcnt [3];
  slot_t s1;

  function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
    logic [9:0] r;
    case (c)
      2'd0:    r = C00;
      2'd1:    r = C01;
      2'd2:    r = C10;
      default: r = C11;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] ref_sym(input logic [7:0] d, input logic de,
                                         input logic [1:0] c, input int ch);
    int         n1d, n1, n0;
    bit         xn;
    logic [8:0] qm;
    logic [9:0] q;
    if (!de) begin
      mcnt[ch] = 0;
      return ctrl_ref(c);
    end
    n1d   = $countones(d);
    xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (mcnt[ch] == 0 || n1 == n0) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      mcnt[ch] += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      mcnt[ch] += -2 * int'(!qm[8]) + n1 - n0;
    end
    return q;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] dd, r;
    dd   = q[9] ? ~q[7:0] : q[7:0];
    r[0] = dd[0];
    for (int i = 1; i < 8; i++) r[i] = q[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i]   = 0;
      s1.sym[i] = C00;
    end
    s1.rgb = '0;
    s1.de  = 1'b0;
  endtask

  // Apply one pixel, advance the model, wait one clock; returns the slot the
  // DUT outputs should now show.
  task automatic drive_cycle(input logic [23:0] rgb, input logic hs, input logic vs,
                             input logic de, output slot_t out_exp);
    slot_t nxt;
    bus0.rgb   = rgb;
    bus0.hsync = hs;
    bus0.vsync = vs;
    bus0.de    = de;
    nxt.rgb    = rgb;
    nxt.de     = de;
    nxt.sym[0] = ref_sym(rgb[7:0], de, {vs, hs}, 0);
    nxt.sym[1] = ref_sym(rgb[15:8], de, 2'b00, 1);
    nxt.sym[2] = ref_sym(rgb[23:16], de, 2'b00, 2);
    out_exp    = s1;
    s1         = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (bus0.tmds0 !== C00) begin errors++; $display("FAIL reset_tmds0 got %b exp %b", bus0.tmds0, C00); end
    if (bus0.tmds1 !== C00) begin errors++; $display("FAIL reset_tmds1 got %b exp %b", bus0.tmds1, C00); end
    if (bus0.tmds2 !== C00) begin errors++; $display("FAIL reset_tmds2 got %b exp %b", bus0.tmds2, C00); end
    if (bus1.tmds0 !== C00) begin errors++; $display("FAIL reset_inv_tmds0 got %b exp %b", bus1.tmds0, C00); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_control();
    slot_t e;
    logic [1:0] c;
    for (int k = 0; k < 4; k++) begin
      c = 2'(k);
      drive_cycle(24'h0, c[0], c[1], 1'b0, e);
      drive_cycle(24'h0, c[0], c[1], 1'b0, e);
      checks += 4;
      if (bus0.tmds0 !== ctrl_ref(c)) begin
        errors++; $display("FAIL ctrl_ch0 c=%b got %b exp %b", c, bus0.tmds0, ctrl_ref(c));
      end
      if (bus0.tmds1 !== C00) begin errors++; $display("FAIL ctrl_ch1 got %b exp %b", bus0.tmds1, C00); end
      if (bus0.tmds2 !== C00) begin errors++; $display("FAIL ctrl_ch2 got %b exp %b", bus0.tmds2, C00); end
      if (bus1.tmds0 !== ctrl_ref(~c)) begin
        errors++; $display("FAIL ctrl_inv_ch0 c=%b got %b exp %b", c, bus1.tmds0, ctrl_ref(~c));
      end
    end
    // hsync=1, vsync=0 explicitly
    drive_cycle(24'h0, 1'b1, 1'b0, 1'b0, e);
    drive_cycle(24'h0, 1'b1, 1'b0, 1'b0, e);
    checks += 2;
    if (bus0.tmds0 !== C01) begin errors++; $display("FAIL hsync_only got %b exp %b", bus0.tmds0, C01); end
    if (bus1.tmds0 !== C10) begin errors++; $display("FAIL hsync_only_inv got %b exp %b", bus1.tmds0, C10); end
  endtask

  task automatic test_zero_data();
    slot_t      e;
    logic [9:0] want [3];
    want[0] = 10'h100;
    want[1] = 10'h3FF;
    want[2] = 10'h100;
    drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, e);
    drive_cycle(24'h0, 1'b0, 1'b0, 1'b1, e);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(24'h0, 1'b0, 1'b0, 1'b1, e);
      checks += 4;
      if (bus0.tmds0 !== want[i]) begin errors++; $display("FAIL zero_ch0 i=%0d got %h exp %h", i, bus0.tmds0, want[i]); end
      if (bus0.tmds1 !== want[i]) begin errors++; $display("FAIL zero_ch1 i=%0d got %h exp %h", i, bus0.tmds1, want[i]); end
      if (bus0.tmds2 !== want[i]) begin errors++; $display("FAIL zero_ch2 i=%0d got %h exp %h", i, bus0.tmds2, want[i]); end
      if (bus1.tmds0 !== want[i]) begin errors++; $display("FAIL zero_inv_ch0 i=%0d got %h exp %h", i, bus1.tmds0, want[i]); end
    end
  endtask

  task automatic test_random(input int n);
    slot_t      e;
    logic [9:0] got [3];
    logic [1:0] sy;
    logic       de;
    for (int i = 0; i < n; i++) begin
      de = ($urandom_range(0, 15) != 0);
      sy = 2'($urandom_range(0, 3));
      drive_cycle(24'($urandom), sy[0], sy[1], de, e);
      got[0] = bus0.tmds0;
      got[1] = bus0.tmds1;
      got[2] = bus0.tmds2;
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (got[ch] !== e.sym[ch]) begin
          errors++; $display("FAIL rand_sym i=%0d ch=%0d got %b exp %b", i, ch, got[ch], e.sym[ch]);
        end
        if (e.de) begin
          checks++;
          if (decode(got[ch]) !== e.rgb[8*ch +: 8]) begin
            errors++;
            $display("FAIL rand_decode i=%0d ch=%0d got %h exp %h", i, ch, decode(got[ch]), e.rgb[8*ch +: 8]);
          end
        end
      end
      if (e.de) begin
        checks++;
        if (bus1.tmds0 !== e.sym[0]) begin
          errors++; $display("FAIL rand_inv_ch0 i=%0d got %b exp %b", i, bus1.tmds0, e.sym[0]);
        end
      end
    end
  endtask

  task automatic test_de_toggle();
    slot_t e;
    logic  pat [5];
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 5; k++) begin
        drive_cycle(24'($urandom), 1'b1, 1'b0, pat[k], e);
        checks += 3;
        if (bus0.tmds0 !== e.sym[0]) begin errors++; $display("FAIL toggle_ch0 r=%0d k=%0d got %b exp %b", r, k, bus0.tmds0, e.sym[0]); end
        if (bus0.tmds1 !== e.sym[1]) begin errors++; $display("FAIL toggle_ch1 r=%0d k=%0d got %b exp %b", r, k, bus0.tmds1, e.sym[1]); end
        if (bus0.tmds2 !== e.sym[2]) begin errors++; $display("FAIL toggle_ch2 r=%0d k=%0d got %b exp %b", r, k, bus0.tmds2, e.sym[2]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    slot_t e;
    for (int k = 0; k < 5; k++) drive_cycle(24'($urandom), 1'b0, 1'b0, 1'b1, e);
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus0.tmds0 !== C00) begin errors++; $display("FAIL midrst_ch0 got %b exp %b", bus0.tmds0, C00); end
    if (bus0.tmds1 !== C00) begin errors++; $display("FAIL midrst_ch1 got %b exp %b", bus0.tmds1, C00); end
    if (bus0.tmds2 !== C00) begin errors++; $display("FAIL midrst_ch2 got %b exp %b", bus0.tmds2, C00); end
    if (bus1.tmds0 !== C00) begin errors++; $display("FAIL midrst_inv_ch0 got %b exp %b", bus1.tmds0, C00); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(24'($urandom), 1'b0, 1'b0, 1'b1, e);
      checks += 3;
      if (bus0.tmds0 !== e.sym[0]) begin errors++; $display("FAIL postrst_ch0 k=%0d got %b exp %b", k, bus0.tmds0, e.sym[0]); end
      if (bus0.tmds1 !== e.sym[1]) begin errors++; $display("FAIL postrst_ch1 k=%0d got %b exp %b", k, bus0.tmds1, e.sym[1]); end
      if (bus0.tmds2 !== e.sym[2]) begin errors++; $display("FAIL postrst_ch2 k=%0d got %b exp %b", k, bus0.tmds2, e.sym[2]); end
    end
  endtask

  initial begin
    bus0.rgb   = '0;
    bus0.hsync = 1'b0;
    bus0.vsync = 1'b0;
    bus0.de    = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_control();
    test_zero_data();
    test_random(10000);
    test_de_toggle();
    test_mid_reset();
    test_random(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
